// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch resolve, 2-bit bimodal predictor and statistics
//
// Ports:
//   clk                 rising-edge clock
//   i_rst_n             asynchronous active-low reset
//   i_pred_pc           fetch PC to predict
//   o_pred_taken        combinational prediction for i_pred_pc
//   i_valid             resolve request present
//   i_branch            resolving instruction is a branch or jump
//   i_branch_op         comparison selector
//   i_a, i_b            compare operands
//   i_pc                PC of resolving instruction (selects table entry to train)
//   i_pred_taken        prediction previously made for that instruction
//   i_stats_clr         synchronous clear of both statistics counters
//   o_valid/o_take/o_mispredict         registered resolve result
//   o_branch_count/o_mispredict_count   saturating statistics
module branch_predict_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [PC_WIDTH-1:0]   i_pred_pc,
  output logic                  o_pred_taken,
  input  logic                  i_valid,
  input  logic                  i_branch,
  input  logic [2:0]            i_branch_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [PC_WIDTH-1:0]   i_pc,
  input  logic                  i_pred_taken,
  input  logic                  i_stats_clr,
  output logic                  o_valid,
  output logic                  o_take,
  output logic                  o_mispredict,
  output logic [CNT_WIDTH-1:0]  o_branch_count,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_BEQ      = 3'b000;
  localparam logic [2:0] OP_BNE      = 3'b001;
  localparam logic [2:0] OP_JAL_JALR = 3'b010;
  localparam logic [2:0] OP_BLT      = 3'b100;
  localparam logic [2:0] OP_BGE      = 3'b101;
  localparam logic [2:0] OP_BLTU     = 3'b110;
  localparam logic [2:0] OP_BGEU     = 3'b111;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]           bht_q [BHT_DEPTH];
  logic [1:0]           bht_d [BHT_DEPTH];
  logic                 valid_q, valid_d;
  logic                 take_q, take_d;
  logic                 mispredict_q, mispredict_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             cond;
  logic             taken;
  logic             mispredict;
  logic             train;
  logic             unused_pc_bits;

  // Word-aligned PCs: bits [1:0] never distinguish instructions.
  assign pred_idx = i_pred_pc[IDX_W+1:2];
  assign upd_idx  = i_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{i_pred_pc[PC_WIDTH-1:IDX_W+2], i_pred_pc[1:0],
                            i_pc[PC_WIDTH-1:IDX_W+2], i_pc[1:0]};

  always_comb begin
    cond = 1'b0;
    case (i_branch_op)
      OP_BEQ:      cond = (i_a == i_b);
      OP_BNE:      cond = (i_a != i_b);
      OP_JAL_JALR: cond = 1'b1;
      OP_BLT:      cond = ($signed(i_a) <  $signed(i_b));
      OP_BGE:      cond = ($signed(i_a) >= $signed(i_b));
      OP_BLTU:     cond = (i_a <  i_b);
      OP_BGEU:     cond = (i_a >= i_b);
      default:     cond = 1'b0;
    endcase
  end

  assign taken      = i_branch & cond;
  assign mispredict = i_valid & (taken ^ i_pred_taken);
  // Only conditional branches train; jumps are always taken and reserved ops carry no outcome.
  assign train      = i_valid & i_branch & (i_branch_op != OP_JAL_JALR) & (i_branch_op != 3'b011);

  // Reading the registered table gives read-before-write when both indices collide.
  assign o_pred_taken = bht_q[pred_idx][1];

  always_comb begin
    bht_d = bht_q;
    if (train) begin
      if (taken && (bht_q[upd_idx] != 2'b11)) begin
        bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else if (!taken && (bht_q[upd_idx] != 2'b00)) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  always_comb begin
    valid_d      = i_valid;
    take_d       = i_valid & taken;
    mispredict_d = mispredict;

    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (i_stats_clr) begin
      branch_count_d     = '0;
      mispredict_count_d = '0;
    end else begin
      if (i_valid && i_branch && (branch_count_q != CNT_MAX)) begin
        branch_count_d = branch_count_q + 1'b1;
      end
      if (mispredict && (mispredict_count_q != CNT_MAX)) begin
        mispredict_count_d = mispredict_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
      valid_q            <= 1'b0;
      take_q             <= 1'b0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      valid_q            <= valid_d;
      take_q             <= take_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign o_valid            = valid_q;
  assign o_take             = take_q;
  assign o_mispredict       = mispredict_q;
  assign o_branch_count     = branch_count_q;
  assign o_mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_pred_pc;
  logic        i_valid, i_branch, i_pred_taken, i_stats_clr;
  logic [2:0]  i_branch_op;
  logic [31:0] i_a, i_b, i_pc;

  logic        o_pred_taken, o_valid, o_take, o_mispredict;
  logic [15:0] o_branch_count, o_mispredict_count;
  logic        c2_pred_taken, c2_valid, c2_take, c2_mispredict;
  logic [1:0]  c2_branch_count, c2_mispredict_count;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_pred_pc(i_pred_pc), .o_pred_taken(o_pred_taken),
    .i_valid(i_valid), .i_branch(i_branch), .i_branch_op(i_branch_op), .i_a(i_a), .i_b(i_b),
    .i_pc(i_pc), .i_pred_taken(i_pred_taken), .i_stats_clr(i_stats_clr),
    .o_valid(o_valid), .o_take(o_take), .o_mispredict(o_mispredict),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
  );

  branch_predict_unit #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .i_rst_n(i_rst_n), .i_pred_pc(i_pred_pc), .o_pred_taken(c2_pred_taken),
    .i_valid(i_valid), .i_branch(i_branch), .i_branch_op(i_branch_op), .i_a(i_a), .i_b(i_b),
    .i_pc(i_pc), .i_pred_taken(i_pred_taken), .i_stats_clr(i_stats_clr),
    .o_valid(c2_valid), .o_take(c2_take), .o_mispredict(c2_mispredict),
    .o_branch_count(c2_branch_count), .o_mispredict_count(c2_mispredict_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model
  logic [1:0] bht_m [64];
  int bc16, mc16, bc2, mc2;

  typedef struct {
    logic valid, take, misp;
    int   bc16, mc16, bc2, mc2;
  } exp_t;
  exp_t sb_q[$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic model_take(input logic br, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
    logic c;
    case (op)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd2: c = 1'b1;
      3'd4: c = ($signed(a) <  $signed(b));
      3'd5: c = ($signed(a) >= $signed(b));
      3'd6: c = (a <  b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    return br && c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    bc16 = 0; mc16 = 0; bc2 = 0; mc2 = 0;
    sb_q.delete();
  endtask

  // Drives one cycle, checks the combinational prediction, pushes the expected
  // registered result, then pops and compares it after the edge.
  task automatic do_cycle(input logic v, input logic br, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                          input logic pt, input logic clr, input logic [31:0] ppc);
    exp_t e, g;
    logic tk, mp;
    int   ix;
    i_valid = v; i_branch = br; i_branch_op = op; i_a = a; i_b = b;
    i_pc = pc; i_pred_taken = pt; i_stats_clr = clr; i_pred_pc = ppc;
    #1;
    check("pred_taken", o_pred_taken, bht_m[idx_of(ppc)][1]);
    tk = model_take(br, op, a, b);
    mp = v && (tk ^ pt);
    if (clr) begin
      bc16 = 0; mc16 = 0; bc2 = 0; mc2 = 0;
    end else begin
      if (v && br) begin
        if (bc16 < 65535) bc16++;
        if (bc2 < 3) bc2++;
      end
      if (mp) begin
        if (mc16 < 65535) mc16++;
        if (mc2 < 3) mc2++;
      end
    end
    if (v && br && op != 3'd2 && op != 3'd3) begin
      ix = idx_of(pc);
      if (tk && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'd1;
      else if (!tk && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'd1;
    end
    e.valid = v; e.take = v && tk; e.misp = mp;
    e.bc16 = bc16; e.mc16 = mc16; e.bc2 = bc2; e.mc2 = mc2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check("o_valid", o_valid, g.valid);
    check("o_take", o_take, g.take);
    check("o_mispredict", o_mispredict, g.misp);
    check("o_branch_count", o_branch_count, g.bc16);
    check("o_mispredict_count", o_mispredict_count, g.mc16);
    check("c2_branch_count", c2_branch_count, g.bc2);
    check("c2_mispredict_count", c2_mispredict_count, g.mc2);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pc;
    logic        br;
    logic        exp_take;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] pool[6];

  initial begin
    vecs[0]  = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h100, 1'b1, 1'b0};
    vecs[1]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h100, 1'b1, 1'b1};
    vecs[2]  = '{3'd6, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h100, 1'b1, 1'b0};
    vecs[3]  = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h100, 1'b1, 1'b1};
    vecs[4]  = '{3'd4, 32'hFFFFFFFF, 32'h00000001, 32'h104, 1'b1, 1'b1};
    vecs[5]  = '{3'd6, 32'hFFFFFFFF, 32'h00000001, 32'h104, 1'b1, 1'b0};
    vecs[6]  = '{3'd5, 32'h80000000, 32'h7FFFFFFF, 32'h108, 1'b1, 1'b0};
    vecs[7]  = '{3'd7, 32'h80000000, 32'h7FFFFFFF, 32'h108, 1'b1, 1'b1};
    vecs[8]  = '{3'd0, 32'h12345678, 32'h12345678, 32'h10C, 1'b1, 1'b1};
    vecs[9]  = '{3'd3, 32'h00000000, 32'h00000000, 32'h080, 1'b1, 1'b0};
    vecs[10] = '{3'd2, 32'h00000000, 32'h00000001, 32'h080, 1'b1, 1'b1};
    vecs[11] = '{3'd2, 32'h00000000, 32'h00000001, 32'h080, 1'b0, 1'b0};
    pool = '{32'h0, 32'h1, 32'h5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    i_rst_n = 1'b0; i_valid = 0; i_branch = 0; i_branch_op = 0; i_a = 0; i_b = 0;
    i_pc = 0; i_pred_taken = 0; i_stats_clr = 0; i_pred_pc = 0;
    model_reset();
    #12;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_take", o_take, 0);
    check("rst_o_mispredict", o_mispredict, 0);
    check("rst_branch_count", o_branch_count, 0);
    check("rst_mispredict_count", o_mispredict_count, 0);
    for (int p = 0; p < 256; p += 4) begin
      i_pred_pc = p;
      #0.1;
      check("rst_pred_taken", o_pred_taken, 0);
    end
    #0.5;
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    // Compare decode, one-cycle latency, jumps and disabled branches
    for (int i = 0; i < 12; i++) begin
      do_cycle(1, vecs[i].br, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].pc, 0, 0, vecs[i].pc);
      check($sformatf("vec%0d_take", i), o_take, vecs[i].exp_take);
    end
    i_pred_pc = 32'h80;
    #1;
    check("jump_no_train", o_pred_taken, 0);

    // Training at PC 0x40 with read-before-write on a colliding index
    do_cycle(1, 1, 3'd0, 7, 7, 32'h40, 0, 0, 32'h40);
    check("train1_pred", o_pred_taken, 1);
    do_cycle(1, 1, 3'd0, 7, 7, 32'h40, 1, 0, 32'h40);
    do_cycle(1, 1, 3'd0, 7, 7, 32'h40, 1, 0, 32'h40);
    do_cycle(1, 1, 3'd0, 7, 8, 32'h40, 1, 0, 32'h40);
    check("train_nt_pred", o_pred_taken, 1);
    do_cycle(0, 1, 3'd0, 7, 8, 32'h40, 0, 0, 32'h40);
    do_cycle(0, 1, 3'd0, 7, 8, 32'h40, 0, 0, 32'h40);
    check("invalid_no_train", o_pred_taken, 1);

    // Mispredict
    do_cycle(0, 0, 3'd0, 0, 0, 0, 0, 1, 32'h40);
    do_cycle(1, 1, 3'd1, 5, 5, 32'h200, 1, 0, 32'h200);
    check("bne_mispredict", o_mispredict, 1);
    check("bne_misp_count", o_mispredict_count, 1);
    check("bne_branch_count", o_branch_count, 1);

    // Saturation at CNT_WIDTH=2 and clear priority
    do_cycle(0, 0, 3'd0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) do_cycle(1, 1, 3'd0, 1, 1, 32'h204, 0, 0, 0);
    check("c2_saturate", c2_branch_count, 3);
    do_cycle(1, 1, 3'd0, 1, 2, 32'h204, 1, 1, 0);
    check("clr_branch_count", o_branch_count, 0);
    check("clr_misp_count", o_mispredict_count, 0);
    check("clr_resolve_kept", o_mispredict, 1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
               pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)],
               {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0, {22'd0, 8'($urandom_range(0, 255)), 2'b00});
    end

    // Mid-operation reset with o_valid high
    do_cycle(1, 1, 3'd0, 3, 3, 32'h40, 0, 0, 32'h40);
    do_cycle(1, 1, 3'd0, 3, 3, 32'h40, 0, 0, 32'h40);
    check("pre_reset_valid", o_valid, 1);
    check("pre_reset_pred", o_pred_taken, 1);
    #2;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_o_take", o_take, 0);
    check("midrst_branch_count", o_branch_count, 0);
    check("midrst_pred", o_pred_taken, 0);
    model_reset();
    #2;
    i_rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", o_valid, 0);
    do_cycle(1, 1, 3'd2, 0, 0, 32'h40, 0, 0, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
